// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register for the pipelined LEGv8 CPU with integrated
// load-use stall and taken-branch flush sequencing, plus saturating
// stall/flush event counters.
module if_id_hazard_reg #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic [63:0]      pc_in,
  input  logic             branch_taken,
  input  logic             freeze,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  output logic [31:0]      instr_out,
  output logic [63:0]      pc_out,
  output logic             valid_out,
  output logic             pc_write_en,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [2:0] LAT3 = 3'(LOAD_LAT);

  state_t           state, state_nxt;
  logic [2:0]       scnt, scnt_nxt, scnt_inc;
  logic [31:0]      instr_nxt;
  logic [63:0]      pc_nxt;
  logic             valid_nxt;
  logic [CNT_W-1:0] stall_nxt, flush_nxt;
  logic             load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Conservative load-use detect: all three register fields of the ID
  // instruction are compared whatever its format; X31 (XZR) never hazards.
  always_comb begin
    load_use = valid_out & ex_memread & (ex_rd != 5'd31) &
               ((ex_rd == instr_out[9:5]) | (ex_rd == instr_out[20:16]) |
                (ex_rd == instr_out[4:0]));
  end

  assign scnt_inc = scnt + 3'd1;

  // Next-state, register-load and control-output decode; branch beats
  // freeze beats load_use in both states.
  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    instr_nxt   = instr_out;
    pc_nxt      = pc_out;
    valid_nxt   = valid_out;
    stall_nxt   = stall_count;
    flush_nxt   = flush_count;
    pc_write_en = 1'b1;
    id_bubble   = 1'b0;

    case (state)
      RUN: begin
        if (branch_taken) begin
          instr_nxt = '0;
          valid_nxt = 1'b0;
          pc_nxt    = pc_in;
          flush_nxt = sat_inc(flush_count);
          scnt_nxt  = '0;
        end else if (freeze) begin
          pc_write_en = 1'b0;
        end else if (load_use) begin
          pc_write_en = 1'b0;
          id_bubble   = 1'b1;
          stall_nxt   = sat_inc(stall_count);
          scnt_nxt    = 3'd1;
          if (LOAD_LAT > 1) state_nxt = STALL;
        end else begin
          instr_nxt = instr_in;
          pc_nxt    = pc_in;
          valid_nxt = 1'b1;
          scnt_nxt  = '0;
        end
      end
      STALL: begin
        pc_write_en = 1'b0;
        id_bubble   = 1'b1;
        if (branch_taken) begin
          // A flush aborts the remaining stall cycles.
          instr_nxt = '0;
          valid_nxt = 1'b0;
          pc_nxt    = pc_in;
          flush_nxt = sat_inc(flush_count);
          scnt_nxt  = '0;
          state_nxt = RUN;
        end else if (!freeze) begin
          stall_nxt = sat_inc(stall_count);
          scnt_nxt  = scnt_inc;
          if (scnt_inc == LAT3) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (reset) begin
      pc_write_en = 1'b1;
      id_bubble   = 1'b0;
    end
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      scnt        <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state       <= state_nxt;
      scnt        <= scnt_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_nxt;
      valid_out   <= valid_nxt;
      stall_count <= stall_nxt;
      flush_count <= flush_nxt;
    end
  end

endmodule
